// File: rtl/ram_port_initiator.sv
// Valid/ready front end for one synchronous RAM port: issues requests, captures the
// registered read word one cycle later and returns in-order responses via a small buffer.
module ram_port_initiator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(RSP_DEPTH);

    logic                  inflight_q, inflight_d;
    logic                  tag_q, tag_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RSP_DEPTH-1:0]  buf_we_q;
    logic [DATA_WIDTH-1:0] buf_data_q [RSP_DEPTH];
    logic                  fire;
    logic                  push;
    logic                  pop;

    // Credit rule: every issued request already owns a buffer slot, so ram_q is never dropped.
    assign req_ready = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_OCC;
    assign fire      = req_valid & req_ready;

    assign ram_addr  = req_addr;
    assign ram_data  = req_wdata;
    assign ram_we    = req_we & fire;

    assign push      = inflight_q;
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_we    = buf_we_q[rd_ptr_q];
    assign rsp_rdata = buf_data_q[rd_ptr_q];

    always_comb begin
        inflight_d = fire;
        tag_d      = req_we;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_we_q <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                buf_data_q[i] <= '0;
            end
        end else if (push) begin
            buf_we_q[wr_ptr_q]   <= tag_q;
            buf_data_q[wr_ptr_q] <= ram_q;
        end
    end
endmodule
